mem_arbiter: RTL

- Shares the single byte-wide RAM/IO port between the instruction fetcher (IF) and the load/store unit (LS).
- Turns each granted request into a sequence of 1-, 2- or 4-byte bus transactions, little-endian, and returns a one-cycle ok pulse to the requester.
- Handles IO back-pressure, pipeline flush of fetches and rdy_in pause.
- Sits between the fetcher/LSU and the top-level mem_* pins.

---
 rtl/mem_arbiter.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Shares the byte-wide memory port between fetch (IF) and load/store (LS), LS first; each request
// becomes 1/2/4 little-endian byte cycles plus a one-cycle ok. rdy_in=0 freezes state; a full IO buffer stalls writes.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter logic [1:0]  IO_SEL = 2'b11
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              io_buffer_full,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              IF_MC_ask,
  input  logic [ADDR_W-1:0] IF_MC_Addr,
  input  logic              IF_MC_clr,
  output logic              MC_IF_ok,
  output logic [31:0]       MC_IF_Inst,
  input  logic              LS_MC_ask,
  input  logic              LS_MC_wr,
  input  logic [ADDR_W-1:0] LS_MC_Addr,
  input  logic [1:0]        LS_MC_len,
  input  logic [31:0]       LS_MC_Data,
  output logic              MC_LS_ok,
  output logic [31:0]       MC_LS_Data
);

  typedef enum logic [1:0] {IDLE, IF_RD, LS_RD, LS_WR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        n_q, n_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [31:0]       wdat_q, wdat_d;
  logic [31:0]       rbuf_q, rbuf_d;
  logic              paused_q;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic [7:0]        mem_dout_q, mem_dout_d;
  logic              mem_wr_q, mem_wr_d;
  logic              if_ok_q, if_ok_d;
  logic              ls_ok_q, ls_ok_d;
  logic [31:0]       if_inst_q, if_inst_d;
  logic [31:0]       ls_data_q, ls_data_d;

  logic [1:0] bidx;
  logic       grant_io_blk;
  logic       wr_io_blk;

  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Byte i lands two edges after its address went out, i.e. at counter value i+2.
  assign bidx         = cnt_q[1:0] - 2'd2;
  assign grant_io_blk = io_buffer_full && (LS_MC_Addr[17:16] == IO_SEL);
  assign wr_io_blk    = io_buffer_full && (addr_q[17:16] == IO_SEL);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    n_d        = n_q;
    cnt_d      = cnt_q;
    wdat_d     = wdat_q;
    rbuf_d     = rbuf_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = mem_wr_q;
    if_ok_d    = if_ok_q;
    ls_ok_d    = ls_ok_q;
    if_inst_d  = if_inst_q;
    ls_data_d  = ls_data_q;
    if (rdy_in) begin
      if_ok_d = 1'b0;
      ls_ok_d = 1'b0;
      case (state_q)
        IDLE: begin
          mem_a_d    = '0;
          mem_dout_d = 8'h00;
          mem_wr_d   = 1'b0;
          cnt_d      = 3'd0;
          // A live ok forces a dead cycle so the requester can drop ask.
          if (!if_ok_q && !ls_ok_q) begin
            if (LS_MC_ask) begin
              addr_d = LS_MC_Addr;
              n_d    = len_bytes(LS_MC_len);
              wdat_d = LS_MC_Data;
              rbuf_d = '0;
              if (LS_MC_wr) begin
                state_d = LS_WR;
                if (!grant_io_blk) begin
                  mem_a_d    = LS_MC_Addr;
                  mem_dout_d = LS_MC_Data[7:0];
                  mem_wr_d   = 1'b1;
                  cnt_d      = 3'd1;
                end
              end else begin
                state_d = LS_RD;
                mem_a_d = LS_MC_Addr;
                cnt_d   = 3'd1;
              end
            end else if (IF_MC_ask && !IF_MC_clr) begin
              state_d = IF_RD;
              addr_d  = IF_MC_Addr;
              n_d     = 3'd4;
              rbuf_d  = '0;
              mem_a_d = IF_MC_Addr;
              cnt_d   = 3'd1;
            end
          end
        end
        IF_RD, LS_RD: begin
          if (state_q == IF_RD && IF_MC_clr) begin
            state_d = IDLE;
            mem_a_d = '0;
            cnt_d   = 3'd0;
          end else if (paused_q) begin
            // Bytes in flight during a pause are stale: replay the whole read.
            mem_a_d = addr_q;
            cnt_d   = 3'd1;
          end else begin
            mem_a_d = (cnt_q < n_q) ? addr_q + ADDR_W'(cnt_q) : '0;
            if (cnt_q >= 3'd2) rbuf_d[{bidx, 3'b000} +: 8] = mem_din;
            if (cnt_q == n_q + 3'd1) begin
              state_d = IDLE;
              cnt_d   = 3'd0;
              if (state_q == IF_RD) begin
                if_ok_d   = 1'b1;
                if_inst_d = rbuf_d;
              end else begin
                ls_ok_d   = 1'b1;
                ls_data_d = rbuf_d;
              end
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        LS_WR: begin
          if (cnt_q < n_q) begin
            if (wr_io_blk) begin
              mem_a_d    = '0;
              mem_dout_d = 8'h00;
              mem_wr_d   = 1'b0;
            end else begin
              mem_a_d    = addr_q + ADDR_W'(cnt_q);
              mem_dout_d = wdat_q[{cnt_q[1:0], 3'b000} +: 8];
              mem_wr_d   = 1'b1;
              cnt_d      = cnt_q + 3'd1;
            end
          end else begin
            state_d    = IDLE;
            mem_a_d    = '0;
            mem_dout_d = 8'h00;
            mem_wr_d   = 1'b0;
            cnt_d      = 3'd0;
            ls_ok_d    = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      n_q        <= 3'd0;
      cnt_q      <= 3'd0;
      wdat_q     <= '0;
      rbuf_q     <= '0;
      paused_q   <= 1'b0;
      mem_a_q    <= '0;
      mem_dout_q <= 8'h00;
      mem_wr_q   <= 1'b0;
      if_ok_q    <= 1'b0;
      ls_ok_q    <= 1'b0;
      if_inst_q  <= '0;
      ls_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      n_q        <= n_d;
      cnt_q      <= cnt_d;
      wdat_q     <= wdat_d;
      rbuf_q     <= rbuf_d;
      paused_q   <= ~rdy_in;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
      if_ok_q    <= if_ok_d;
      ls_ok_q    <= ls_ok_d;
      if_inst_q  <= if_inst_d;
      ls_data_q  <= ls_data_d;
    end
  end

  assign mem_a      = mem_a_q;
  assign mem_dout   = mem_dout_q;
  assign mem_wr     = mem_wr_q & rdy_in;
  assign MC_IF_ok   = if_ok_q;
  assign MC_IF_Inst = if_inst_q;
  assign MC_LS_ok   = ls_ok_q;
  assign MC_LS_Data = ls_data_q;

endmodule
